// File: rtl/hilo_div_ctrl.sv
`timescale 1ns/1ps
// hilo_div_ctrl
// Sequencer and HI/LO holding register sitting between the control unit and
// the sequential divider (and, optionally, the multiplier). Launches an
// operation, waits for its result, captures it into HI/LO, flags
// divide-by-zero and serves mthi/mtlo writes while idle.
//
// Optional feature macro: HILO_MULT_EN (compiles in the multiply path).
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   div_req, mult_req         operation requests (sampled only when idle)
//   mthi, mtlo, wdata         HI/LO writes (sampled only when idle)
//   div_hi, div_lo, div_zero  divider remainder, quotient, divide-by-zero flag
//   div_start, div_clear      one-cycle start / clear pulses to the divider
//   mult_start                one-cycle start pulse to the multiplier
//   mult_done, mult_hi/lo     multiplier result-valid pulse and result
//   hi, lo                    architectural HI and LO
//   busy                      operation in flight (pipeline stall)
//   done                      one-cycle pulse: HI/LO updated by an operation
//   div0_exc                  one-cycle divide-by-zero exception pulse
module hilo_div_ctrl #(
    parameter int unsigned DIV_LATENCY = 33
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        div_req,
    input  logic        mult_req,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        div_zero,
    output logic        div_start,
    output logic        div_clear,
    output logic        mult_start,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0_exc
);

    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX        = '1;
    // cnt is 1 on the edge after the divider sampled div_start
    localparam logic [CNT_W-1:0] ZERO_CHECK_CNT = CNT_W'(1);
    localparam logic [CNT_W-1:0] CAPTURE_CNT    = CNT_W'(DIV_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_EXC  = 2'd2,
        MULT_RUN = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

`ifndef HILO_MULT_EN
    // Multiply path absent: its inputs are deliberately unused
    logic unused_mult;
    assign unused_mult = ^{mult_req, mult_done, mult_hi, mult_lo};
    assign mult_start  = 1'b0;
`endif

    // Sequencer state, counter and all registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            div_start <= 1'b0;
            div_clear <= 1'b0;
`ifdef HILO_MULT_EN
            mult_start <= 1'b0;
`endif
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div0_exc  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    div0_exc <= 1'b0;
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    // divide wins; a losing multiply request is dropped
                    if (div_req) begin
                        state     <= DIV_RUN;
                        div_start <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                    end
`ifdef HILO_MULT_EN
                    else if (mult_req) begin
                        state      <= MULT_RUN;
                        mult_start <= 1'b1;
                        busy       <= 1'b1;
                    end
`endif
                end

                DIV_RUN: begin
                    div_start <= 1'b0;
                    if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                    if (cnt == ZERO_CHECK_CNT && div_zero) begin
                        state     <= DIV_EXC;
                        div0_exc  <= 1'b1;
                        div_clear <= 1'b1;
                    end else if (cnt == CAPTURE_CNT) begin
                        hi    <= div_hi;
                        lo    <= div_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                DIV_EXC: begin
                    div0_exc  <= 1'b0;
                    div_clear <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

`ifdef HILO_MULT_EN
                MULT_RUN: begin
                    mult_start <= 1'b0;
                    if (mult_done) begin
                        hi    <= mult_hi;
                        lo    <= mult_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Sequencer and HI/LO holding register between the control unit and the sequential divider (and, optionally, the multiplier). It launches a divide or multiply, counts the divider's fixed latency, and captures the result into the architectural HI/LO registers. It detects divide-by-zero, raises a one-cycle exception pulse and clears the divider. It also provides `busy` for pipeline stall and serves mthi/mtlo writes.

## Interface
- `DIV_LATENCY`, default 33: clock edges from the divider sampling start to its hi/lo outputs being valid.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `div_req`  in  1  start divide; sampled only in IDLE.
- `mult_req`  in  1  start multiply; sampled only in IDLE.
- `mthi`, `mtlo`  in  1  write `wdata` to HI or LO; sampled only in IDLE.
- `wdata`  in  32  data for mthi/mtlo.
- `div_hi`, `div_lo`  in  32  divider remainder and quotient.
- `div_zero`  in  1  divider divide-by-zero flag.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_clear`  out  1  one-cycle clear pulse to the divider; the top level ORs it into the divider reset.
- `mult_start`  out  1  one-cycle start pulse to the multiplier.
- `mult_done`  in  1  multiplier result-valid pulse.
- `mult_hi`, `mult_lo`  in  32  multiplier result.
- `hi`, `lo`  out  32  architectural HI and LO.
- `busy`  out  1  operation in flight; the control unit stalls.
- `done`  out  1  one-cycle pulse; HI/LO were updated by an operation.
- `div0_exc`  out  1  one-cycle divide-by-zero exception pulse.

## Operation
- All outputs are registered. Reset drives every output to 0, sets the state to IDLE and clears the counter.
- Reset mid-operation aborts the operation with no capture. HI/LO return to 0.
- State IDLE:
  - If `div_req` is high: go to DIV_RUN, set `div_start`<=1, `busy`<=1, `cnt`<=0.
  - Else if `mult_req` is high: go to MULT_RUN, set `mult_start`<=1, `busy`<=1.
  - `div_req` has priority over `mult_req`. The losing request is ignored and must be re-presented.
  - `mthi`/`mtlo` write HI/LO in the same edge, independent of any request. Both may be high together.
- State DIV_RUN:
  - `div_start`<=0 after one cycle.
  - `cnt` increments every edge. It is 6-bit and saturates; it never wraps.
  - At the edge where `cnt`==1, if `div_zero` is high: go to DIV_EXC, set `div0_exc`<=1 and `div_clear`<=1. HI/LO are not written.
  - At the edge where `cnt`==DIV_LATENCY+1: `hi`<=`div_hi`, `lo`<=`div_lo`, `done`<=1, `busy`<=0, go to IDLE.
- State DIV_EXC: for one cycle only, set `div0_exc`<=0, `div_clear`<=0, `busy`<=0, then go to IDLE.
- State MULT_RUN: `mult_start`<=0 after one cycle. At the first edge where `mult_done` is high: capture `mult_hi`/`mult_lo`, set `done`<=1, `busy`<=0, go to IDLE. No timeout.
- In any state other than IDLE, `div_req`, `mult_req`, `mthi` and `mtlo` are ignored.

## Timing
- Let edge A be the edge that accepts `div_req`.
  - `div_start` is high during the cycle A to A+1. The divider samples it at A+1.
  - `div_zero` is checked at A+2. On divide-by-zero, `div0_exc` and `div_clear` are high during A+2 to A+3, and `busy` falls at A+3.
  - Normal capture happens at A+DIV_LATENCY+2, which is A+35 by default. `done` is high for the following cycle, and `busy` falls on the same edge.
- Multiply: capture happens at the edge sampling `mult_done`. `done` is high for the next cycle.
- `done` and `div0_exc` are never high in the same cycle.
- A back-to-back request is accepted at the edge immediately after `busy` falls.

## Configuration
- `HILO_MULT_EN` defined: the MULT_RUN path is compiled in.
- `HILO_MULT_EN` undefined:
  - `mult_req`, `mult_done`, `mult_hi` and `mult_lo` are ignored.
  - `mult_start` is tied to 0.
  - Ports remain present.

## Test plan
- Reset, then 100/7 through the team divider, `div_req` at edge A → `busy` high from A to A+35; `hi`=2, `lo`=14 at A+35; `done` pulses once.
- −100/7 (A=0xFFFFFF9C) → `lo`=0xFFFFFFF2 at A+35. `hi` equals the divider's `div_hi`.
- Reset, then `mthi` with `wdata`=0xDEADBEEF and `mtlo` with 0x12345678, then 5/0 →
  - `div0_exc` and `div_clear` high only during A+2 to A+3.
  - `hi`/`lo` remain 0xDEADBEEF/0x12345678; `done` never pulses.
  - A following 9/3 gives `lo`=3, `hi`=0.
- Assert `reset` when `cnt`=10 → next cycle all outputs are 0 and state is IDLE. A new `div_req` is accepted and gives a correct result.
- With `HILO_MULT_EN`: `div_req` and `mult_req` high together → only `div_start` pulses. `mult_start` stays 0 until `mult_req` is re-presented after `busy` falls. `mult_done` with `mult_hi`=1, `mult_lo`=2 → `hi`=1, `lo`=2.
- `mthi` asserted while `busy` is high → HI unchanged.
